fifo_circ: RTL and testbench

Parametrised synchronous FIFO built on a circular buffer with read/write pointers; no data shifting on pop.
Successor to the fixed 4-bit x 16 FIFO, adding:
- configurable width and depth;
- simultaneous push/pop;
- occupancy count;
- almost-full/almost-empty thresholds;
- sticky overflow/underflow flags;
- synchronous flush.

Sits between producer and consumer logic in the same clock domain.

---
 rtl/fifo_pkg.sv | 52 +++++
 rtl/fifo_circ_if.sv | 36 +++
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_circ.sv | 133 +++++++++++++
 tb/tb_fifo_circ.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the circular-buffer FIFO: width rules, flag bundle,
// request encoding and the parameter legality predicate.
package fifo_pkg;

    // Request outcome for one edge, {push_ok, pop_ok}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_EMPTY = '{
        full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1
    };

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Count must hold DEPTH itself, hence DEPTH+1 states.
    function automatic int count_w(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic int addr_w(input int depth);
        return (clog2(depth) > 1) ? clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int depth,
                                     input int af_level, input int ae_level);
        return (width >= 1) && (depth >= 2) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_circ_if.sv
// Producer/consumer-side bundle of the circular FIFO; the FIFO itself takes
// the slave view.
interface fifo_circ_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
);
    import fifo_pkg::*;

    localparam int CW = count_w(DEPTH);

    logic             clr;
    logic             push;
    logic [WIDTH-1:0] d;
    logic             pop;
    logic [WIDTH-1:0] q;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, push, d, pop,
        input  q, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

    modport slave (
        input  clr, push, d, pop,
        output q, full, empty, almost_full, almost_empty, count,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage with one synchronous write port and one registered
// read port; contents are deliberately not reset.
module fifo_ram #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_circ.sv
// Parametrised synchronous FIFO on a circular buffer: pointers, occupancy,
// registered status flags and sticky error flags around fifo_ram.
module fifo_circ
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic       clk,
    input logic       reset,
    fifo_circ_if.slave bus
);

    localparam int CW = count_w(DEPTH);
    localparam int AW = addr_w(DEPTH);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
        $error("fifo_circ: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_nxt;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    fifo_flags_t      flags;
    logic             ovf;
    logic             unf;
    logic             q_vld;
    logic             push_ok;
    logic             pop_ok;
    logic             we;
    logic             re;
    fifo_op_e         op;
    logic [WIDTH-1:0] rdata;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic fifo_flags_t flags_of(input logic [CW-1:0] c);
        fifo_flags_t f;
        f.full         = (c == CW'(DEPTH));
        f.empty        = (c == '0);
        f.almost_full  = (c >= CW'(AF_LEVEL));
        f.almost_empty = (c <= CW'(AE_LEVEL));
        return f;
    endfunction

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        push_ok    = bus.push & (~flags.full | bus.pop);
        pop_ok     = bus.pop & ~flags.empty;
        op         = fifo_op_e'({push_ok, pop_ok});
        cnt_nxt    = cnt;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        case (op)
            OP_PUSH: cnt_nxt = cnt + 1'b1;
            OP_POP:  cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
        if (push_ok) begin
            wr_ptr_nxt = ptr_inc(wr_ptr);
        end
        if (pop_ok) begin
            rd_ptr_nxt = ptr_inc(rd_ptr);
        end
        we = push_ok & ~bus.clr;
        re = pop_ok & ~bus.clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            flags  <= FLAGS_EMPTY;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            q_vld  <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            flags  <= FLAGS_EMPTY;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            flags  <= flags_of(cnt_nxt);
            if (bus.push & ~push_ok) begin
                ovf <= 1'b1;
            end
            if (bus.pop & ~pop_ok) begin
                unf <= 1'b1;
            end
            if (pop_ok) begin
                q_vld <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (bus.d),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // The RAM read register has no reset; q reads as zero until the first pop.
    assign bus.q            = q_vld ? rdata : '0;
    assign bus.count        = cnt;
    assign bus.full         = flags.full;
    assign bus.empty        = flags.empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;

endmodule

// File: tb/tb_fifo_circ.sv
// Directed bench for fifo_circ: a 4x16 instance with default thresholds and
// an 8x5 instance for pointer wrap-around.
module tb_fifo_circ;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_circ_if #(.WIDTH(4), .DEPTH(16)) b16 ();
    fifo_circ_if #(.WIDTH(8), .DEPTH(5))  b5 ();

    fifo_circ #(.WIDTH(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (b16)
    );

    fifo_circ #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (b5)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr16();
        b16.clr = 1'b1;
        cyc();
        b16.clr = 1'b0;
    endtask

    logic [7:0] wv;
    logic [7:0] rv;

    initial begin
        reset   = 1'b0;
        b16.clr = 1'b0; b16.push = 1'b0; b16.pop = 1'b0; b16.d = 4'h0;
        b5.clr  = 1'b0; b5.push  = 1'b0; b5.pop  = 1'b0; b5.d  = 8'h00;

        // 1: reset with push held
        b16.push = 1'b1;
        b16.d    = 4'h7;
        repeat (3) cyc();
        chk("t1_count_rst", 32'(b16.count), 32'd0);
        chk("t1_empty_rst", 32'(b16.empty), 32'd1);
        chk("t1_ae_rst", 32'(b16.almost_empty), 32'd1);
        chk("t1_full_rst", 32'(b16.full), 32'd0);
        chk("t1_af_rst", 32'(b16.almost_full), 32'd0);
        chk("t1_q_rst", 32'(b16.q), 32'd0);
        chk("t1_ovf_rst", 32'(b16.overflow), 32'd0);
        chk("t1_unf_rst", 32'(b16.underflow), 32'd0);
        b16.push = 1'b0;
        reset    = 1'b1;
        cyc();
        chk("t1_count_rel", 32'(b16.count), 32'd0);
        chk("t1_empty_rel", 32'(b16.empty), 32'd1);
        b16.pop = 1'b1;
        cyc();
        b16.pop = 1'b0;
        chk("t1_unf_nowrite", 32'(b16.underflow), 32'd1);
        chk("t1_q_nowrite", 32'(b16.q), 32'd0);
        chk("t1_count_nowrite", 32'(b16.count), 32'd0);
        clr16();
        chk("t1_unf_clr", 32'(b16.underflow), 32'd0);

        // 2: fill, overflow, drain
        for (int i = 1; i <= 16; i++) begin
            b16.push = 1'b1;
            b16.d    = 4'(i);
            cyc();
            if (i == 2)  chk("t2_ae_at2", 32'(b16.almost_empty), 32'd1);
            if (i == 3)  chk("t2_ae_at3", 32'(b16.almost_empty), 32'd0);
            if (i == 13) chk("t2_af_at13", 32'(b16.almost_full), 32'd0);
            if (i == 14) chk("t2_af_at14", 32'(b16.almost_full), 32'd1);
        end
        b16.push = 1'b0;
        chk("t2_count_full", 32'(b16.count), 32'd16);
        chk("t2_full", 32'(b16.full), 32'd1);
        chk("t2_af", 32'(b16.almost_full), 32'd1);
        chk("t2_ovf_before", 32'(b16.overflow), 32'd0);
        b16.push = 1'b1;
        b16.d    = 4'h9;
        cyc();
        b16.push = 1'b0;
        chk("t2_ovf", 32'(b16.overflow), 32'd1);
        chk("t2_count_ovf", 32'(b16.count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            b16.pop = 1'b1;
            cyc();
            chk("t2_q", 32'(b16.q), 32'(i & 15));
            chk("t2_count_drain", 32'(b16.count), 32'(16 - i));
        end
        b16.pop = 1'b0;
        chk("t2_empty", 32'(b16.empty), 32'd1);
        chk("t2_ovf_sticky", 32'(b16.overflow), 32'd1);
        clr16();

        // 3: push+pop while full
        for (int i = 0; i < 16; i++) begin
            b16.push = 1'b1;
            b16.d    = 4'((i + 3) & 15);
            cyc();
        end
        b16.pop = 1'b1;
        b16.d   = 4'hA;
        cyc();
        b16.push = 1'b0;
        b16.pop  = 1'b0;
        chk("t3_q_oldest", 32'(b16.q), 32'h3);
        chk("t3_count", 32'(b16.count), 32'd16);
        chk("t3_full", 32'(b16.full), 32'd1);
        chk("t3_ovf", 32'(b16.overflow), 32'd0);
        for (int i = 0; i < 15; i++) begin
            b16.pop = 1'b1;
            cyc();
            chk("t3_drain", 32'(b16.q), 32'((i + 4) & 15));
        end
        cyc();
        b16.pop = 1'b0;
        chk("t3_tail", 32'(b16.q), 32'hA);
        chk("t3_empty", 32'(b16.empty), 32'd1);

        // 4: push+pop while empty
        b16.push = 1'b1;
        b16.pop  = 1'b1;
        b16.d    = 4'h5;
        cyc();
        b16.push = 1'b0;
        b16.pop  = 1'b0;
        chk("t4_count", 32'(b16.count), 32'd1);
        chk("t4_unf", 32'(b16.underflow), 32'd1);
        chk("t4_q_held", 32'(b16.q), 32'hA);
        chk("t4_empty", 32'(b16.empty), 32'd0);
        b16.pop = 1'b1;
        cyc();
        b16.pop = 1'b0;
        chk("t4_q", 32'(b16.q), 32'h5);
        chk("t4_empty_after", 32'(b16.empty), 32'd1);
        clr16();

        // 5: wrap-around on the 5-deep instance
        wv = 8'h10;
        rv = 8'h10;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) begin
                b5.push = 1'b1; b5.d = wv; wv = wv + 8'd1;
                cyc();
            end
            b5.push = 1'b0;
            chk("t5_count3", 32'(b5.count), 32'd3);
            chk("t5_af3", 32'(b5.almost_full), 32'd1);
            for (int k = 0; k < 3; k++) begin
                b5.pop = 1'b1;
                cyc();
                chk("t5_q3", 32'(b5.q), 32'(rv));
                rv = rv + 8'd1;
            end
            b5.pop = 1'b0;
            for (int k = 0; k < 5; k++) begin
                b5.push = 1'b1; b5.d = wv; wv = wv + 8'd1;
                cyc();
            end
            b5.push = 1'b0;
            chk("t5_count5", 32'(b5.count), 32'd5);
            chk("t5_full5", 32'(b5.full), 32'd1);
            for (int k = 0; k < 5; k++) begin
                b5.pop = 1'b1;
                cyc();
                chk("t5_q5", 32'(b5.q), 32'(rv));
                rv = rv + 8'd1;
            end
            b5.pop = 1'b0;
            chk("t5_empty", 32'(b5.empty), 32'd1);
        end

        // 6: mid-stream clr, then asynchronous reset mid-burst
        for (int i = 0; i < 16; i++) begin
            b16.push = 1'b1;
            b16.d    = 4'(i);
            cyc();
        end
        cyc();
        b16.push = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b16.pop = 1'b1;
            cyc();
        end
        b16.pop = 1'b0;
        chk("t6_count7", 32'(b16.count), 32'd7);
        chk("t6_ovf_set", 32'(b16.overflow), 32'd1);
        chk("t6_q_before", 32'(b16.q), 32'h8);
        b16.clr  = 1'b1;
        b16.push = 1'b1;
        b16.d    = 4'hC;
        cyc();
        b16.clr  = 1'b0;
        b16.push = 1'b0;
        chk("t6_count_clr", 32'(b16.count), 32'd0);
        chk("t6_ovf_clr", 32'(b16.overflow), 32'd0);
        chk("t6_empty_clr", 32'(b16.empty), 32'd1);
        chk("t6_q_held", 32'(b16.q), 32'h8);
        b16.push = 1'b1;
        b16.d    = 4'h3;
        cyc();
        b16.push = 1'b0;
        b16.pop  = 1'b1;
        cyc();
        b16.pop  = 1'b0;
        chk("t6_q_after_clr", 32'(b16.q), 32'h3);
        chk("t6_empty_after", 32'(b16.empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            b16.push = 1'b1;
            b16.d    = 4'(i + 1);
            cyc();
        end
        chk("t6_count_burst", 32'(b16.count), 32'd5);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_count", 32'(b16.count), 32'd0);
        chk("t6_async_empty", 32'(b16.empty), 32'd1);
        chk("t6_async_q", 32'(b16.q), 32'd0);
        chk("t6_async_ae", 32'(b16.almost_empty), 32'd1);
        b16.push = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("t6_count_post", 32'(b16.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
